// File: rtl/medidor_frequencia_if.sv
// Control/status bundle of the frequency meter: measurement requests in,
// window status and the published edge count out.
`timescale 1ns/100ps
interface medidor_frequencia_if #(
  parameter int CNT_W = 32
) ();
  logic             start;
  logic             cont;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (output start, cont, input busy, done, count, overflow);
  modport slave  (input start, cont, output busy, done, count, overflow);
endinterface

// File: rtl/medidor_frequencia.sv
// Frequency meter: counts rising edges of an asynchronous slow signal over a
// gate window of GATE_CYCLES clk cycles and publishes the total with a
// one-cycle done pulse. Optional continuous mode re-arms after each window.
`timescale 1ns/100ps
module medidor_frequencia #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  medidor_frequencia_if.slave bus
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sdly_q;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [CNT_W-1:0]       edges_q, edges_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   rise;

  // Single-cycle pulse on each synchronised rising edge of sig_in.
  assign rise = sync_q[SYNC_STAGES-1] & ~sdly_q;

  // Metastability synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sdly_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sdly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // State, window counters and published result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gate_q     <= '0;
      edges_q    <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edges_q    <= edges_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: open a window, count rises (saturating), publish the
  // total on the last gate cycle so it is valid together with done.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edges_d    = edges_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_GATE;
          gate_d  = GATE_LOAD;
          edges_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_GATE: begin
        if (rise) begin
          if (edges_q == CNT_MAX) ovf_d = 1'b1;
          else                    edges_d = edges_q + 1'b1;
        end
        if (gate_q == '0) begin
          state_d    = S_DONE;
          count_d    = edges_d;
          overflow_d = ovf_d;
        end else begin
          gate_d = gate_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.cont) begin
          state_d = S_GATE;
          gate_d  = GATE_LOAD;
          edges_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q == S_GATE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_medidor_frequencia.sv
// Testbench for medidor_frequencia: two instances (8-bit and 4-bit counters)
// share clk, reset and sig_in; a window-level reference model predicts every
// done pulse and a negedge monitor checks the DUT outputs against it.
`timescale 1ns/100ps
module tb_medidor_frequencia;
  localparam int GC = 100;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;

  medidor_frequencia_if #(.CNT_W(8)) bus8 ();
  medidor_frequencia_if #(.CNT_W(4)) bus4 ();

  medidor_frequencia #(.GATE_CYCLES(GC), .CNT_W(8), .SYNC_STAGES(SS)) dut8 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus8));
  medidor_frequencia #(.GATE_CYCLES(GC), .CNT_W(4), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus4));

  always #5 clk = ~clk;

  typedef struct {
    int     cnt;
    bit     ovf;
    longint cyc;
  } exp_t;

  exp_t   q8[$];
  exp_t   q4[$];
  int     compared = 0;
  int     mismatched = 0;
  longint cyc = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // ---------------- sig_in generator ----------------
  int mode = 0;   // 0 hold low, 1 square wave, 2 toggle every clk, 3 async
  int half = 5;
  int ph = 0;
  initial forever begin
    if (mode == 3) begin
      #(36.7 + real'($urandom_range(0, 30)));
      while (mode == 3) begin
        sig_in = ~sig_in;
        #36.5;
      end
    end else begin
      @(negedge clk);
      case (mode)
        0: sig_in = 1'b0;
        1: begin
          ph++;
          if (ph >= half) begin ph = 0; sig_in = ~sig_in; end
        end
        2: sig_in = ~sig_in;
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  // A rising transition of the sampled sig_in (0 at edge j-1, 1 at edge j)
  // is credited to clock edge j+SS. A window opened by a request at edge N
  // credits edges N+1..N+GC and its result is shown in the cycle after N+GC.
  // One edge after that the meter either re-arms (cont) or goes idle.
  bit     hist[0:SS];
  bit     in_win[2];
  longint win_end[2];
  longint done_at[2];
  int     sum[2];
  int     maxv[2] = '{255, 15};
  bit     m_r;
  bit     m_st[2];
  bit     m_ct[2];

  always @(posedge clk) begin
    cyc++;
    m_st[0] = bus8.start; m_st[1] = bus4.start;
    m_ct[0] = bus8.cont;  m_ct[1] = bus4.cont;
    m_r = hist[SS-1] & ~hist[SS];
    for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = sig_in;
    if (!rst_n) begin
      for (int j = 0; j <= SS; j++) hist[j] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        in_win[i] = 1'b0;
        done_at[i] = -1;
      end
      q8.delete();
      q4.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_win[i]) begin
          sum[i] += int'(m_r);
          if (cyc == win_end[i]) begin
            exp_t e;
            e.cnt = (sum[i] > maxv[i]) ? maxv[i] : sum[i];
            e.ovf = (sum[i] > maxv[i]);
            e.cyc = cyc;
            in_win[i] = 1'b0;
            done_at[i] = cyc + 1;
            if (i == 0) q8.push_back(e);
            else        q4.push_back(e);
          end
        end else if (cyc == done_at[i]) begin
          if (m_ct[i]) begin
            in_win[i] = 1'b1; win_end[i] = cyc + GC; sum[i] = 0;
          end
        end else if (m_st[i]) begin
          in_win[i] = 1'b1; win_end[i] = cyc + GC; sum[i] = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int pub_cnt[2];
  bit pub_ovf[2];

  task automatic mon(input int i, input string nm, input logic b, input logic d,
                     input logic [7:0] c, input logic o);
    exp_t e;
    bit   have;
    bit   exp_d;
    chk({nm, "_no_x"}, longint'($isunknown({b, d, c, o})), 0);
    if (!rst_n) begin
      pub_cnt[i] = 0;
      pub_ovf[i] = 1'b0;
      chk({nm, "_rst_busy"}, b, 0);
      chk({nm, "_rst_done"}, d, 0);
      chk({nm, "_rst_count"}, c, 0);
      chk({nm, "_rst_ovf"}, o, 0);
      return;
    end
    have = 1'b0;
    if (i == 0 && q8.size() > 0) begin e = q8[0]; have = 1'b1; end
    if (i == 1 && q4.size() > 0) begin e = q4[0]; have = 1'b1; end
    exp_d = have && (e.cyc == cyc);
    chk({nm, "_done"}, d, exp_d);
    if (exp_d) begin
      pub_cnt[i] = e.cnt;
      pub_ovf[i] = e.ovf;
      if (i == 0) void'(q8.pop_front());
      else        void'(q4.pop_front());
    end
    chk({nm, "_count"}, c, pub_cnt[i]);
    chk({nm, "_overflow"}, o, pub_ovf[i]);
    chk({nm, "_busy"}, b, in_win[i]);
  endtask

  always @(negedge clk) begin
    mon(0, "d8", bus8.busy, bus8.done, bus8.count, bus8.overflow);
    mon(1, "d4", bus4.busy, bus4.done, {4'b0, bus4.count}, bus4.overflow);
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start8();
    @(negedge clk); bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bus8.start = 1'b0; bus8.cont = 1'b0;
    bus4.start = 1'b0; bus4.cont = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // sig_in held low: count 0 published
    mode = 0;
    idle($urandom_range(1, 9));
    pulse_start8();
    idle(GC + 5);

    // square wave, period 10 clk, single shot
    mode = 1; half = 5;
    idle($urandom_range(3, 17));
    pulse_start8();
    idle(GC + 5);

    // asynchronous reset in the middle of a window
    pulse_start8();
    idle($urandom_range(10, 80));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus8.busy, 0);
    chk("async_rst_done", bus8.done, 0);
    chk("async_rst_count", bus8.count, 0);
    idle(3);
    #2 rst_n = 1'b1;
    idle(GC + 20);

    // continuous mode, period 20 wave, stray start pulses during windows
    mode = 1; half = 10;
    bus8.cont = 1'b1;
    pulse_start8();
    repeat (350) begin
      @(negedge clk);
      bus8.start = ($urandom_range(0, 9) == 0);
    end
    bus8.start = 1'b0;
    bus8.cont = 1'b0;
    idle(2 * GC + 10);

    // asynchronous sig_in, period 7.3 clk, continuous windows
    mode = 3;
    bus8.cont = 1'b1;
    idle($urandom_range(2, 20));
    pulse_start8();
    idle(4 * (GC + 1) + $urandom_range(0, 50));
    bus8.cont = 1'b0;
    idle(GC + 10);

    // toggle every clk: 50 rises, 4-bit counter saturates
    mode = 2;
    idle(4);
    @(negedge clk); bus8.start = 1'b1; bus4.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0; bus4.start = 1'b0;
    idle(GC + 5);
    mode = 0;
    idle(5);

    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
